// File: rtl/axil_sram_responder_pkg.sv
// Shared response codes, FSM state encodings and address-window helper
// for the AXI4-lite SRAM responder.
package axil_sram_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      R_IDLE = 3'd0,
      R_WAIT = 3'd1,
      R_RESP = 3'd2
   } rd_state_t;

   typedef enum logic [2:0] {
      W_IDLE = 3'd0,
      W_WAIT = 3'd1,
      W_RESP = 3'd2
   } wr_state_t;

   // Offset is addr - BASE_ADDR in unsigned 32-bit arithmetic, so addresses below the base wrap high and miss.
   function automatic logic in_window(input logic [31:0] offset, input int depth_log2);
      return offset < (32'd8 << depth_log2);
   endfunction

endpackage

// File: rtl/axil_sram_responder_if.sv
// AXI4-lite load/store bus between the LSU-side initiator (master) and the
// SRAM responder (slave).
interface axil_sram_responder_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axil_sram_responder_sram.sv
// 64-bit wide SRAM with one byte-masked synchronous write port and one
// asynchronous read port; contents are never reset.
module sram_bytemask_mem #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [7:0]            wbe,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [63:0]           wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [63:0]           rdata
);

   logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (wbe[i]) begin
               mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Async read: a write committing on the same edge as a read sample returns the old word.
   assign rdata = mem[raddr];

endmodule

// File: rtl/axil_sram_responder.sv
// AXI4-lite responder serving reads and writes from a byte-maskable SRAM,
// with independent read/write FSMs and programmable response latency.
module axil_sram_responder
   import axil_sram_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          RD_LAT     = 2,
   parameter int          WR_LAT     = 1
) (
   input logic                 clk,
   input logic                 rst,
   axil_sram_responder_if.slave bus
);

   localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
   localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

   rd_state_t rd_state, rd_next;
   logic [3:0]  rd_cnt;
   logic [31:0] ar_addr_q;
   logic [31:0] rd_addr;
   logic [31:0] rd_offset;
   logic        rd_hit;
   logic        rd_load;
   logic [63:0] mem_rdata;

   wr_state_t wr_state, wr_next;
   logic [3:0]  wr_cnt;
   logic        aw_held, w_held;
   logic [31:0] aw_addr_q;
   logic [63:0] w_data_q;
   logic [7:0]  w_strb_q;
   logic        aw_hs, w_hs, both_held;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;
   logic [7:0]  wr_strb;
   logic [31:0] wr_offset;
   logic        wr_hit;
   logic        wr_enter;
   logic        mem_we;

   always_comb begin
      rd_next     = rd_state;
      bus.arready = 1'b0;
      case (rd_state)
         R_IDLE: begin
            bus.arready = 1'b1;
            if (bus.arvalid) begin
               rd_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
            end
         end
         R_WAIT: if (rd_cnt == 4'd1) rd_next = R_RESP;
         R_RESP: if (bus.rready) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   // With zero latency the sample happens on the AR handshake edge, so the live address is used.
   assign rd_addr    = (rd_state == R_IDLE) ? bus.araddr : ar_addr_q;
   assign rd_offset  = rd_addr - BASE_ADDR;
   assign rd_hit     = in_window(rd_offset, DEPTH_LOG2);
   assign rd_load    = (rd_next == R_RESP) && (rd_state != R_RESP);
   assign bus.rvalid = (rd_state == R_RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state  <= R_IDLE;
         rd_cnt    <= 4'd0;
         ar_addr_q <= 32'd0;
         bus.rdata <= 64'd0;
         bus.rresp <= RESP_OKAY;
      end else begin
         rd_state <= rd_next;
         if (rd_state == R_IDLE && bus.arvalid) begin
            ar_addr_q <= bus.araddr;
            rd_cnt    <= RD_LAT_C;
         end else if (rd_state == R_WAIT) begin
            rd_cnt <= rd_cnt - 4'd1;
         end
         if (rd_load) begin
            bus.rdata <= rd_hit ? mem_rdata : 64'd0;
            bus.rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   always_comb begin
      wr_next     = wr_state;
      bus.awready = (wr_state == W_IDLE) && !aw_held;
      bus.wready  = (wr_state == W_IDLE) && !w_held;
      aw_hs       = bus.awvalid && bus.awready;
      w_hs        = bus.wvalid && bus.wready;
      both_held   = (aw_held || aw_hs) && (w_held || w_hs);
      case (wr_state)
         W_IDLE: if (both_held) wr_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
         W_WAIT: if (wr_cnt == 4'd1) wr_next = W_RESP;
         W_RESP: if (bus.bready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   // Whichever of AW/W arrives on the completing edge has not been latched yet, so bypass it.
   assign wr_addr    = aw_held ? aw_addr_q : bus.awaddr;
   assign wr_data    = w_held ? w_data_q : bus.wdata;
   assign wr_strb    = w_held ? w_strb_q : bus.wstrb;
   assign wr_offset  = wr_addr - BASE_ADDR;
   assign wr_hit     = in_window(wr_offset, DEPTH_LOG2);
   assign wr_enter   = (wr_next == W_RESP) && (wr_state != W_RESP);
   assign mem_we     = wr_enter && wr_hit && !rst;
   assign bus.bvalid = (wr_state == W_RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state  <= W_IDLE;
         wr_cnt    <= 4'd0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= 32'd0;
         w_data_q  <= 64'd0;
         w_strb_q  <= 8'd0;
         bus.bresp <= RESP_OKAY;
      end else begin
         wr_state <= wr_next;
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= bus.awaddr;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
         end
         if (wr_state == W_IDLE && both_held) begin
            wr_cnt <= WR_LAT_C;
         end else if (wr_state == W_WAIT) begin
            wr_cnt <= wr_cnt - 4'd1;
         end
         if (wr_enter) begin
            bus.bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
         end
         if (wr_state == W_RESP && bus.bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
      end
   end

   sram_bytemask_mem #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .wbe  (wr_strb),
      .waddr(wr_offset[DEPTH_LOG2+2:3]),
      .wdata(wr_data),
      .raddr(rd_offset[DEPTH_LOG2+2:3]),
      .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_axil_sram_responder.sv
// Scoreboard bench for axil_sram_responder: drivers queue expected R/B
// responses, a negedge monitor pops and compares them on each handshake.
module tb_axil_sram_responder;
   import axil_sram_responder_pkg::*;

   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   axil_sram_responder_if bus();

   axil_sram_responder #(
      .BASE_ADDR (32'h8000_0000),
      .DEPTH_LOG2(12),
      .RD_LAT    (RD_LAT),
      .WR_LAT    (WR_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
   } rexp_t;

   rexp_t       rq[$];
   logic [1:0]  bq[$];
   int          compared   = 0;
   int          mismatched = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard pops on R/B handshakes plus hold/stability of a stalled read response.
   logic        prev_rhold = 1'b0;
   logic [63:0] prev_rdata;
   logic [1:0]  prev_rresp;
   rexp_t       r_e;
   logic [1:0]  b_e;

   always @(negedge clk) begin
      if (rst) begin
         prev_rhold = 1'b0;
      end else begin
         if (prev_rhold) begin
            checkOutput("rvalid_held", 64'(bus.rvalid), 64'd1);
            checkOutput("rdata_stable", bus.rdata, prev_rdata);
            checkOutput("rresp_stable", 64'(bus.rresp), 64'(prev_rresp));
         end
         prev_rhold = bus.rvalid && !bus.rready;
         prev_rdata = bus.rdata;
         prev_rresp = bus.rresp;
         if (bus.rvalid && bus.rready) begin
            if (rq.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL r_unexpected: got rvalid with rdata %h, expected no response", bus.rdata);
            end else begin
               r_e = rq.pop_front();
               checkOutput("rdata", bus.rdata, r_e.data);
               checkOutput("rresp", 64'(bus.rresp), 64'(r_e.resp));
            end
         end
         if (bus.bvalid && bus.bready) begin
            if (bq.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL b_unexpected: got bvalid with bresp %h, expected no response", bus.bresp);
            end else begin
               b_e = bq.pop_front();
               checkOutput("bresp", 64'(bus.bresp), 64'(b_e));
            end
         end
      end
   end

   task automatic writeTxn(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input int w_lead, input logic [1:0] exp_resp);
      int n;
      bq.push_back(exp_resp);
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      if (w_lead > 0) begin
         bus.wvalid = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!bus.wready && n < 50);
         checkOutput("w_accept", 64'(bus.wready), 64'd1);
         @(posedge clk); #1;
         bus.wvalid = 1'b0;
         for (int i = 0; i < w_lead; i++) begin
            @(negedge clk);
            checkOutput("wready_after_w", 64'(bus.wready), 64'd0);
            checkOutput("bvalid_before_aw", 64'(bus.bvalid), 64'd0);
         end
         @(posedge clk); #1;
         bus.awvalid = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
         checkOutput("aw_accept", 64'(bus.awready), 64'd1);
      end else begin
         bus.awvalid = 1'b1;
         bus.wvalid  = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!(bus.awready && bus.wready) && n < 50);
         checkOutput("aw_w_accept", 64'(bus.awready && bus.wready), 64'd1);
      end
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.bvalid && n < 50);
      checkOutput("b_latency", 64'(n), 64'(WR_LAT + 1));
      @(posedge clk); #1;
   endtask

   task automatic readTxn(input logic [31:0] addr, input logic [63:0] exp_data, input logic [1:0] exp_resp,
                          input int hold);
      int    n;
      rexp_t e;
      e.data = exp_data;
      e.resp = exp_resp;
      rq.push_back(e);
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      bus.rready  = (hold == 0);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
      checkOutput("ar_accept", 64'(bus.arready), 64'd1);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rvalid && n < 50);
      checkOutput("r_latency", 64'(n), 64'(RD_LAT + 1));
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         @(posedge clk); #1;
         bus.rready = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus();
      int n;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_arready", 64'(bus.arready), 64'd1);
      checkOutput("rst_awready", 64'(bus.awready), 64'd1);
      checkOutput("rst_wready", 64'(bus.wready), 64'd1);
      checkOutput("rst_rvalid", 64'(bus.rvalid), 64'd0);
      checkOutput("rst_bvalid", 64'(bus.bvalid), 64'd0);
      checkOutput("rst_rdata", bus.rdata, 64'd0);
      checkOutput("rst_rresp", 64'(bus.rresp), 64'd0);
      checkOutput("rst_bresp", 64'(bus.bresp), 64'd0);
      @(posedge clk); #1;

      writeTxn(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, RESP_OKAY);
      readTxn(32'h8000_0010, 64'h1122_3344_5566_7788, RESP_OKAY, 0);

      writeTxn(32'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0, RESP_OKAY);
      readTxn(32'h8000_0013, 64'h1122_3344_BBBB_BBBB, RESP_OKAY, 0);

      writeTxn(32'h8000_0020, 64'h0102_0304_0506_0708, 8'hFF, 0, RESP_OKAY);
      writeTxn(32'h8000_0020, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 2, RESP_OKAY);
      readTxn(32'h8000_0020, 64'hDEAD_BEEF_0506_0708, RESP_OKAY, 0);

      // 0x8000_8000 aliases word 0 if the window check were skipped.
      writeTxn(32'h8000_0000, 64'h5555_AAAA_5555_AAAA, 8'hFF, 0, RESP_OKAY);
      readTxn(32'h7FFF_FFF8, 64'd0, RESP_SLVERR, 0);
      writeTxn(32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, RESP_SLVERR);
      readTxn(32'h8000_0000, 64'h5555_AAAA_5555_AAAA, RESP_OKAY, 0);
      writeTxn(32'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, RESP_OKAY);
      writeTxn(32'h8000_7FF8, 64'h0, 8'h00, 0, RESP_OKAY);
      readTxn(32'h8000_7FFF, 64'h0123_4567_89AB_CDEF, RESP_OKAY, 0);

      readTxn(32'h8000_0010, 64'h1122_3344_BBBB_BBBB, RESP_OKAY, 5);

      writeTxn(32'h8000_0018, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 0, RESP_OKAY);
      bus.awaddr  = 32'h8000_0018;
      bus.wdata   = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.wstrb   = 8'hFF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(bus.awready && bus.wready) && n < 50);
      checkOutput("abort_accept", 64'(bus.awready && bus.wready), 64'd1);
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("bvalid_after_abort", 64'(bus.bvalid), 64'd0);
      end
      @(posedge clk); #1;
      readTxn(32'h8000_0018, 64'h0F0F_0F0F_0F0F_0F0F, RESP_OKAY, 0);

      repeat (5) @(posedge clk);
      checkOutput("rq_drained", 64'(rq.size()), 64'd0);
      checkOutput("bq_drained", 64'(bq.size()), 64'd0);
   endtask

   initial begin
      bus.araddr  = 32'd0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b1;
      bus.awaddr  = 32'd0;
      bus.awvalid = 1'b0;
      bus.wdata   = 64'd0;
      bus.wstrb   = 8'd0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b1;
      applyStimulus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
